// File: rtl/median_pkg.sv
// Shared mode codes and default widths for the 3x3 median/morphology pipeline.
// Latency: none (constants and types only).
// Backpressure: none (no ports).
package median_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int USER_W_DEF = 2;

    // Per-window operation, carried down the pipe alongside its pixel.
    typedef enum logic [1:0] {
        MODE_MEDIAN = 2'd0,
        MODE_MAX    = 2'd1,
        MODE_MIN    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

endpackage

// File: rtl/median3x3_pipe_if.sv
// Window-in / pixel-out valid-ready bus of median3x3_pipe.
// Latency: none (wiring only).
// Backpressure: out_ready throttles in_ready through the filter.
// Signals: in_valid/in_ready/in_win/in_mode/in_user (window side),
//          out_valid/out_ready/out_data/out_user (result side).
// slave = filter side, master = source/sink side.
interface median3x3_pipe_if import median_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int USER_W = USER_W_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [9*DATA_W-1:0]   in_win;
    logic [1:0]            in_mode;
    logic [USER_W-1:0]     in_user;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [USER_W-1:0]     out_user;

    modport slave (
        input  in_valid, in_win, in_mode, in_user, out_ready,
        output in_ready, out_valid, out_data, out_user
    );

    modport master (
        output in_valid, in_win, in_mode, in_user, out_ready,
        input  in_ready, out_valid, out_data, out_user
    );

endinterface

// File: rtl/sort3_stage.sv
// Registered three-input sorter: max / mid / min of i_a, i_b, i_c.
// Latency: 1 cycle; outputs load only when en=1.
// Backpressure: en=0 holds all outputs; rst (sync, active-high) clears them.
// Ports: clk, rst, en, i_a/i_b/i_c (unsigned DATA_W), o_max/o_mid/o_min.
module sort3_stage import median_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    output logic [DATA_W-1:0] o_max,
    output logic [DATA_W-1:0] o_mid,
    output logic [DATA_W-1:0] o_min
);

    logic [DATA_W-1:0] w_ab_hi;
    logic [DATA_W-1:0] w_ab_lo;
    logic [DATA_W-1:0] w_hc_lo;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_mid;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_mid;
    logic [DATA_W-1:0] r_min;

    assign w_ab_hi = (i_a >= i_b) ? i_a : i_b;
    assign w_ab_lo = (i_a >= i_b) ? i_b : i_a;
    assign w_max   = (w_ab_hi >= i_c) ? w_ab_hi : i_c;
    assign w_min   = (w_ab_lo <= i_c) ? w_ab_lo : i_c;
    // With lo <= hi, the middle value is max(lo, min(hi, c)).
    assign w_hc_lo = (w_ab_hi <= i_c) ? w_ab_hi : i_c;
    assign w_mid   = (w_ab_lo >= w_hc_lo) ? w_ab_lo : w_hc_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
            r_mid <= '0;
            r_min <= '0;
        end else if (en) begin
            r_max <= w_max;
            r_mid <= w_mid;
            r_min <= w_min;
        end
    end

    assign o_max = r_max;
    assign o_mid = r_mid;
    assign o_min = r_min;

endmodule

// File: rtl/median3x3_pipe.sv
// 3x3 window filter: median / max (dilate) / min (erode) / bypass centre, per window.
// Latency: 3 cycles (accept edge + 2); one window per cycle at full rate.
// Backpressure: single global advance en = !out_valid || out_ready; in_ready = en.
// Ports: clk, rst (sync, active-high), bus (median3x3_pipe_if.slave).
// Optional MEDIAN3X3_PIXCNT_EN: adds pix_cnt_clr (in) and pix_cnt[31:0] (out),
// a wrapping count of output transfers, cleared by rst or pix_cnt_clr.
module median3x3_pipe import median_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int USER_W = USER_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MEDIAN3X3_PIXCNT_EN
    input  logic                  pix_cnt_clr,
    output logic [31:0]           pix_cnt,
`endif
    median3x3_pipe_if.slave       bus
);

    function automatic logic [DATA_W-1:0] f_max2(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_min2(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a <= b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_mid3(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
        return f_max2(f_min2(a, b), f_min2(f_max2(a, b), c));
    endfunction

    logic              w_en;
    logic [DATA_W-1:0] w_pix     [9];
    logic [DATA_W-1:0] w_row_max [3];
    logic [DATA_W-1:0] w_row_mid [3];
    logic [DATA_W-1:0] w_row_min [3];

    // Stage 1 side-band (row sorts live inside the sorters)
    logic              r_s1_vld;
    mode_e             r_s1_mode;
    logic [USER_W-1:0] r_s1_user;
    logic [DATA_W-1:0] r_s1_ctr;

    // Stage 2: the three median terms plus global max/min and centre
    logic              r_s2_vld;
    mode_e             r_s2_mode;
    logic [USER_W-1:0] r_s2_user;
    logic [DATA_W-1:0] r_s2_lo;
    logic [DATA_W-1:0] r_s2_md;
    logic [DATA_W-1:0] r_s2_hi;
    logic [DATA_W-1:0] r_s2_max;
    logic [DATA_W-1:0] r_s2_min;
    logic [DATA_W-1:0] r_s2_ctr;

    // Stage 3
    logic              r_s3_vld;
    mode_e             r_s3_mode;
    logic [USER_W-1:0] r_s3_user;
    logic [DATA_W-1:0] r_s3_max;
    logic [DATA_W-1:0] r_s3_min;
    logic [DATA_W-1:0] r_s3_ctr;
    logic [DATA_W-1:0] w_s3_med;
    logic [DATA_W-1:0] w_s3_hi_unused;
    logic [DATA_W-1:0] w_s3_lo_unused;
    logic [DATA_W-1:0] w_out_data;

    // Whole pipe advances together; a held result freezes every stage.
    assign w_en        = !r_s3_vld || bus.out_ready;
    assign bus.in_ready = w_en;

    for (genvar gi = 0; gi < 9; gi++) begin : g_pix
        assign w_pix[gi] = bus.in_win[gi*DATA_W +: DATA_W];
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        sort3_stage #(.DATA_W(DATA_W)) u_row_sort (
            .clk   (clk),
            .rst   (rst),
            .en    (w_en),
            .i_a   (w_pix[3*gr]),
            .i_b   (w_pix[3*gr+1]),
            .i_c   (w_pix[3*gr+2]),
            .o_max (w_row_max[gr]),
            .o_mid (w_row_mid[gr]),
            .o_min (w_row_min[gr])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= MODE_MEDIAN;
            r_s1_user <= '0;
            r_s1_ctr  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_mode <= MODE_MEDIAN;
            r_s2_user <= '0;
            r_s2_lo   <= '0;
            r_s2_md   <= '0;
            r_s2_hi   <= '0;
            r_s2_max  <= '0;
            r_s2_min  <= '0;
            r_s2_ctr  <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_mode <= MODE_MEDIAN;
            r_s3_user <= '0;
            r_s3_max  <= '0;
            r_s3_min  <= '0;
            r_s3_ctr  <= '0;
        end else if (w_en) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_mode <= mode_e'(bus.in_mode);
            r_s1_user <= bus.in_user;
            r_s1_ctr  <= w_pix[4];

            // With rows sorted, the median of nine is the middle of
            // min-of-maxes, mid-of-mids and max-of-mins.
            r_s2_vld  <= r_s1_vld;
            r_s2_mode <= r_s1_mode;
            r_s2_user <= r_s1_user;
            r_s2_lo   <= f_min2(w_row_max[0], f_min2(w_row_max[1], w_row_max[2]));
            r_s2_md   <= f_mid3(w_row_mid[0], w_row_mid[1], w_row_mid[2]);
            r_s2_hi   <= f_max2(w_row_min[0], f_max2(w_row_min[1], w_row_min[2]));
            r_s2_max  <= f_max2(w_row_max[0], f_max2(w_row_max[1], w_row_max[2]));
            r_s2_min  <= f_min2(w_row_min[0], f_min2(w_row_min[1], w_row_min[2]));
            r_s2_ctr  <= r_s1_ctr;

            r_s3_vld  <= r_s2_vld;
            r_s3_mode <= r_s2_mode;
            r_s3_user <= r_s2_user;
            r_s3_max  <= r_s2_max;
            r_s3_min  <= r_s2_min;
            r_s3_ctr  <= r_s2_ctr;
        end
    end

    // Only the mid output of this sorter is the median; its max/min are not needed.
    sort3_stage #(.DATA_W(DATA_W)) u_med_sort (
        .clk   (clk),
        .rst   (rst),
        .en    (w_en),
        .i_a   (r_s2_lo),
        .i_b   (r_s2_md),
        .i_c   (r_s2_hi),
        .o_max (w_s3_hi_unused),
        .o_mid (w_s3_med),
        .o_min (w_s3_lo_unused)
    );

    always_comb begin
        w_out_data = w_s3_med;
        case (r_s3_mode)
            MODE_MAX:    w_out_data = r_s3_max;
            MODE_MIN:    w_out_data = r_s3_min;
            MODE_BYPASS: w_out_data = r_s3_ctr;
            default:     w_out_data = w_s3_med;
        endcase
    end

    assign bus.out_valid = r_s3_vld;
    assign bus.out_data  = w_out_data;
    assign bus.out_user  = r_s3_user;

`ifdef MEDIAN3X3_PIXCNT_EN
    logic [31:0] r_pix_cnt;

    // Clear has priority over a same-cycle transfer; the add wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || pix_cnt_clr) begin
            r_pix_cnt <= '0;
        end else if (r_s3_vld && bus.out_ready) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
        end
    end

    assign pix_cnt = r_pix_cnt;
`else
    // No transfer counter in this build; the output stage is unchanged.
`endif

endmodule

// File: tb/tb_median3x3_pipe.sv
// Self-checking bench for median3x3_pipe: directed cases plus random traffic
// against a sort-based reference and an in-order scoreboard.
// Optional MEDIAN3X3_PIXCNT_EN exercises the transfer counter.
module tb_median3x3_pipe;

    localparam int DW = 10;
    localparam int UW = 2;

    typedef logic [9*DW-1:0] win_t;
    typedef struct {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    median3x3_pipe_if #(.DATA_W(DW), .USER_W(UW)) bus ();

`ifdef MEDIAN3X3_PIXCNT_EN
    logic        pix_cnt_clr;
    logic [31:0] pix_cnt;
    int          exp_cnt = 0;
`endif

    median3x3_pipe #(.DATA_W(DW), .USER_W(UW)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MEDIAN3X3_PIXCNT_EN
        .pix_cnt_clr (pix_cnt_clr),
        .pix_cnt     (pix_cnt),
`endif
        .bus         (bus)
    );

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t m_e;
    bit   was_stall = 1'b0;
    logic [DW-1:0] hold_d;
    logic [UW-1:0] hold_u;
    int   ref_px[9] = '{9, 1, 5, 3, 7, 2, 8, 4, 6};
    win_t w_ref;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: sort all nine pixels and pick by rank.
    function automatic logic [DW-1:0] ref_filter(input win_t w, input logic [1:0] mode);
        int v[9];
        int t;
        int ctr;
        for (int i = 0; i < 9; i++) v[i] = int'(w[i*DW +: DW]);
        ctr = v[4];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        case (mode)
            2'd0:    return DW'(v[4]);
            2'd1:    return DW'(v[8]);
            2'd2:    return DW'(v[0]);
            default: return DW'(ctr);
        endcase
    endfunction

    function automatic win_t fill_win(input int val);
        win_t w;
        for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(val);
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        int sty;
        int v;
        sty = int'($urandom_range(0, 2));
        for (int i = 0; i < 9; i++) begin
            case (sty)
                0:       v = int'($urandom_range(0, 1023));
                1:       v = int'($urandom_range(0, 3));
                default: v = ($urandom_range(0, 1) != 0) ? 1023 : 0;
            endcase
            w[i*DW +: DW] = DW'(v);
        end
        return w;
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef MEDIAN3X3_PIXCNT_EN
            chk("pix_cnt_track", pix_cnt, 32'(exp_cnt));
`endif
            if (rst) begin
                sb.delete();
                was_stall = 1'b0;
            end else begin
                chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
                if (was_stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_data", 32'(bus.out_data), 32'(hold_d));
                    chk("stall_user", 32'(bus.out_user), 32'(hold_u));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d with nothing pending, expected no result", bus.out_data);
                    end else begin
                        m_e = sb.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(m_e.d));
                        chk("out_user", 32'(bus.out_user), 32'(m_e.u));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    m_e.d = ref_filter(bus.in_win, bus.in_mode);
                    m_e.u = bus.in_user;
                    sb.push_back(m_e);
                end
                was_stall = bus.out_valid && !bus.out_ready;
                hold_d    = bus.out_data;
                hold_u    = bus.out_user;
            end
`ifdef MEDIAN3X3_PIXCNT_EN
            if (rst || pix_cnt_clr) exp_cnt = 0;
            else if (bus.out_valid && bus.out_ready) exp_cnt++;
`endif
        end
    end

    // Present one window and keep it until accepted (bounded).
    task automatic send(input win_t w, input logic [1:0] m, input logic [UW-1:0] u);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_win   = w;
        bus.in_mode  = m;
        bus.in_user  = u;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    // One window into an idle pipe; result must appear three edges later.
    task automatic single(input win_t w, input logic [1:0] m, input logic [UW-1:0] u,
                          input int exp_d, input string tag);
        int lat;
        lat = 0;
        bus.in_valid = 1'b1;
        bus.in_win   = w;
        bus.in_mode  = m;
        bus.in_user  = u;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
        chk({tag, "_user"}, 32'(bus.out_user), 32'(u));
        @(posedge clk); #1;
    endtask

    task automatic back_to_back();
        int exp_d[4] = '{5, 9, 1, 7};
        int k;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    bus.in_valid = 1'b1;
                    bus.in_win   = w_ref;
                    bus.in_mode  = 2'(i);
                    bus.in_user  = 2'(i);
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin
                k = 0;
                while (k < 12 && !bus.out_valid) begin
                    @(negedge clk);
                    k++;
                end
                for (int i = 0; i < 4; i++) begin
                    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
                    chk("b2b_data", 32'(bus.out_data), 32'(exp_d[i]));
                    chk("b2b_user", 32'(bus.out_user), 32'(i));
                    if (i < 3) @(negedge clk);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic backpressure();
        int exp_d[3] = '{5, 9, 1};
        bus.out_ready = 1'b0;
        send(w_ref, 2'd0, 2'd1);
        send(w_ref, 2'd1, 2'd2);
        send(w_ref, 2'd2, 2'd3);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data", 32'(bus.out_data), 32'd5);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_drain_data", 32'(bus.out_data), 32'(exp_d[i]));
            chk("bp_drain_user", 32'(bus.out_user), 32'(i + 1));
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_stall();
        bus.out_ready = 1'b0;
        send(w_ref, 2'd0, 2'd1);
        send(w_ref, 2'd1, 2'd2);
        send(w_ref, 2'd2, 2'd3);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        // Window offered while still in reset must be dropped.
        bus.in_valid = 1'b1;
        bus.in_win   = fill_win(1023);
        bus.in_mode  = 2'd1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_user", 32'(bus.out_user), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_no_ghost", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        single(w_ref, 2'd0, 2'd2, 5, "post_rst");
    endtask

    task automatic run_random(input int n);
        bit acc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc || !bus.in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_win   = rand_win();
                    bus.in_mode  = 2'($urandom_range(0, 3));
                    bus.in_user  = 2'($urandom_range(0, 3));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 9; i++) w_ref[i*DW +: DW] = DW'(ref_px[i]);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_win    = '0;
        bus.in_mode   = 2'd0;
        bus.in_user   = '0;
        bus.out_ready = 1'b0;
`ifdef MEDIAN3X3_PIXCNT_EN
        pix_cnt_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'd0);
        chk("reset_out_user", 32'(bus.out_user), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // Pin the reference model to hand-computed values.
        chk("model_median", 32'(ref_filter(w_ref, 2'd0)), 32'd5);
        chk("model_max", 32'(ref_filter(w_ref, 2'd1)), 32'd9);
        chk("model_min", 32'(ref_filter(w_ref, 2'd2)), 32'd1);
        chk("model_bypass", 32'(ref_filter(w_ref, 2'd3)), 32'd7);

        single(w_ref, 2'd0, 2'd0, 5, "ref_median");
        single(w_ref, 2'd1, 2'd1, 9, "ref_max");
        single(w_ref, 2'd2, 2'd2, 1, "ref_min");
        single(w_ref, 2'd3, 2'd3, 7, "ref_bypass");

        back_to_back();
        backpressure();

        for (int m = 0; m < 4; m++) begin
            single(fill_win(1023), 2'(m), 2'(m), 1023, "all_ones");
            single(fill_win(0), 2'(m), 2'(3 - m), 0, "all_zero");
        end

        reset_mid_stall();
        run_random(3000);

`ifdef MEDIAN3X3_PIXCNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) send(rand_win(), 2'($urandom_range(0, 3)), 2'(i));
        bus.in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pix_cnt_ten", pix_cnt, 32'd10);
        @(posedge clk); #1;
        send(w_ref, 2'd0, 2'd0);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (bus.out_valid) break;
            @(posedge clk); #1;
        end
        chk("pix_clr_with_xfer_valid", 32'(bus.out_valid), 32'd1);
        pix_cnt_clr = 1'b1;
        @(posedge clk); #1;
        pix_cnt_clr = 1'b0;
        @(negedge clk);
        chk("pix_cnt_clr_wins", pix_cnt, 32'd0);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
